// File: rtl/dir_input_ctrl_if.sv
// Signal bundle between the debounced buttons / maze logic and the
// direction input controller.
interface dir_input_ctrl_if;
    logic       btn_up_i;
    logic       btn_down_i;
    logic       btn_left_i;
    logic       btn_right_i;
    logic       move_tick_i;
    logic [3:0] can_move_i;
    logic [1:0] dir_o;
    logic       moving_o;
    logic       pending_valid_o;
    logic [1:0] pending_dir_o;
    logic       dir_changed_o;
    logic       press_o;

    // Environment side: drives buttons, tick and open-direction mask.
    modport master (
        output btn_up_i, btn_down_i, btn_left_i, btn_right_i,
        output move_tick_i, can_move_i,
        input  dir_o, moving_o, pending_valid_o, pending_dir_o,
        input  dir_changed_o, press_o
    );

    // Controller side.
    modport slave (
        input  btn_up_i, btn_down_i, btn_left_i, btn_right_i,
        input  move_tick_i, can_move_i,
        output dir_o, moving_o, pending_valid_o, pending_dir_o,
        output dir_changed_o, press_o
    );
endinterface

// File: rtl/dir_input_ctrl.sv
// Direction input controller: turns debounced button levels into press
// events, buffers the latest press as a pending turn with a tick-based
// expiry timer, and commits it on a move tick when the maze allows it.
//
// Pending FSM
//   state   | meaning
//   NONE    | no buffered turn
//   ARMED   | buffered turn waiting for an open tile, hold timer running
// Motion FSM
//   state   | meaning
//   STOPPED | Pacman parked (against a wall or after reset)
//   MOVING  | Pacman advancing along dir_o on every move tick
module dir_input_ctrl #(
    parameter int unsigned HOLD_TICKS = 8
) (
    input  logic             clk_i,
    input  logic             reset,
    dir_input_ctrl_if.slave  bus
);
    localparam logic [0:0] NONE    = 1'b0;
    localparam logic [0:0] ARMED   = 1'b1;
    localparam logic [0:0] STOPPED = 1'b0;
    localparam logic [0:0] MOVING  = 1'b1;
    localparam logic [1:0] DIR_LEFT = 2'b10;
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);

    logic [3:0] btn, prev_q, rise;
    logic       press_any;
    logic [1:0] press_dir;

    logic [0:0] pend_state_q, pend_state_d;
    logic [1:0] pend_dir_q, pend_dir_d;
    logic [7:0] hold_q, hold_d;
    logic [0:0] motion_q, motion_d;
    logic [1:0] dir_q, dir_d;
    logic       chg_q, chg_d;
    logic       press_q;

    logic       eff_valid;
    logic [1:0] eff_dir;
    logic [7:0] eff_cnt;
    logic       commit;

    // Bit index equals the direction code (0 up, 1 down, 2 left, 3 right).
    assign btn  = {bus.btn_right_i, bus.btn_left_i, bus.btn_down_i, bus.btn_up_i};
    assign rise = btn & ~prev_q;
    assign press_any = |rise;

    // Priority pick among simultaneous rises: up > down > left > right.
    always_comb begin
        press_dir = 2'b00;
        if (rise[0])      press_dir = 2'b00;
        else if (rise[1]) press_dir = 2'b01;
        else if (rise[2]) press_dir = 2'b10;
        else if (rise[3]) press_dir = 2'b11;
    end

    // A press in this cycle takes precedence over the stored pending turn.
    assign eff_valid = press_any | (pend_state_q == ARMED);
    assign eff_dir   = press_any ? press_dir : pend_dir_q;
    assign eff_cnt   = press_any ? HOLD_LOAD : hold_q;
    assign commit    = bus.move_tick_i & eff_valid & bus.can_move_i[eff_dir];

    // Next-state logic for both FSMs and the hold timer.
    always_comb begin
        pend_state_d = pend_state_q;
        pend_dir_d   = pend_dir_q;
        hold_d       = hold_q;
        motion_d     = motion_q;
        dir_d        = dir_q;
        chg_d        = 1'b0;

        if (press_any) begin
            pend_state_d = ARMED;
            pend_dir_d   = press_dir;
            hold_d       = HOLD_LOAD;
        end

        if (bus.move_tick_i) begin
            if (commit) begin
                pend_state_d = NONE;
                hold_d       = 8'd0;
                dir_d        = eff_dir;
                motion_d     = MOVING;
                chg_d        = (eff_dir != dir_q) || (motion_q == STOPPED);
            end else begin
                if (eff_valid) begin
                    // Terminal count: the tick that takes the timer to zero expires the turn.
                    if (eff_cnt <= 8'd1) begin
                        pend_state_d = NONE;
                        hold_d       = 8'd0;
                    end else begin
                        hold_d = eff_cnt - 8'd1;
                    end
                end
                if (!bus.can_move_i[dir_q]) begin
                    motion_d = STOPPED;
                end else begin
                    motion_d = MOVING;
                    chg_d    = (motion_q == STOPPED);
                end
            end
        end
    end

    // State registers with synchronous reset overriding any same-cycle activity.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            prev_q       <= 4'b0000;
            pend_state_q <= NONE;
            pend_dir_q   <= 2'b00;
            hold_q       <= 8'd0;
            motion_q     <= STOPPED;
            dir_q        <= DIR_LEFT;
            chg_q        <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            prev_q       <= btn;
            pend_state_q <= pend_state_d;
            pend_dir_q   <= pend_dir_d;
            hold_q       <= hold_d;
            motion_q     <= motion_d;
            dir_q        <= dir_d;
            chg_q        <= chg_d;
            press_q      <= press_any;
        end
    end

    assign bus.dir_o           = dir_q;
    assign bus.moving_o        = (motion_q == MOVING);
    assign bus.pending_valid_o = (pend_state_q == ARMED);
    assign bus.pending_dir_o   = pend_dir_q;
    assign bus.dir_changed_o   = chg_q;
    assign bus.press_o         = press_q;
endmodule

// File: tb/tb_dir_input_ctrl.sv
// Bench for dir_input_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the controller.
module tb_dir_input_ctrl;
    localparam int HOLD = 8;

    logic clk_i = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dir_input_ctrl_if bus_if ();

    dir_input_ctrl #(.HOLD_TICKS(HOLD)) dut (
        .clk_i (clk_i),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural model state
    logic [1:0] m_dir;
    bit         m_mov;
    bit         m_pv;
    logic [1:0] m_pd;
    int         m_hold;
    logic [3:0] m_prev;
    bit         m_press;
    bit         m_chg;

    task automatic model(input bit r, input logic [3:0] b, input bit t, input logic [3:0] cm);
        int pidx;
        bit ev;
        logic [1:0] ed;
        int eh;
        if (r) begin
            m_dir = 2'b10; m_mov = 0; m_pv = 0; m_pd = 2'b00; m_hold = 0;
            m_prev = 4'b0000; m_press = 0; m_chg = 0;
            return;
        end
        pidx = -1;
        for (int i = 0; i < 4; i++)
            if (pidx < 0 && b[i] && !m_prev[i]) pidx = i;
        m_prev  = b;
        m_press = (pidx >= 0);
        m_chg   = 0;
        ev = m_press ? 1'b1 : m_pv;
        ed = m_press ? 2'(pidx) : m_pd;
        eh = m_press ? HOLD : m_hold;
        if (m_press) begin
            m_pd = 2'(pidx); m_pv = 1; m_hold = HOLD;
        end
        if (t) begin
            if (ev && cm[ed]) begin
                m_chg = (ed != m_dir) || !m_mov;
                m_dir = ed; m_mov = 1; m_pv = 0; m_hold = 0;
            end else begin
                if (ev) begin
                    m_hold = eh - 1;
                    if (m_hold == 0) m_pv = 0;
                end
                if (!cm[m_dir]) m_mov = 0;
                else begin
                    m_chg = !m_mov;
                    m_mov = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit r, input logic [3:0] b, input bit t, input logic [3:0] cm);
        @(negedge clk_i);
        reset = r;
        bus_if.btn_up_i    = b[0];
        bus_if.btn_down_i  = b[1];
        bus_if.btn_left_i  = b[2];
        bus_if.btn_right_i = b[3];
        bus_if.move_tick_i = t;
        bus_if.can_move_i  = cm;
        model(r, b, t, cm);
        @(posedge clk_i);
        #1;
        chk("dir",     8'(bus_if.dir_o),           8'(m_dir));
        chk("moving",  8'(bus_if.moving_o),        8'(m_mov));
        chk("pvalid",  8'(bus_if.pending_valid_o), 8'(m_pv));
        chk("pdir",    8'(bus_if.pending_dir_o),   8'(m_pd));
        chk("changed", 8'(bus_if.dir_changed_o),   8'(m_chg));
        chk("press",   8'(bus_if.press_o),         8'(m_press));
    endtask

    initial begin
        logic [3:0] rb;
        bus_if.btn_up_i = 0; bus_if.btn_down_i = 0; bus_if.btn_left_i = 0;
        bus_if.btn_right_i = 0; bus_if.move_tick_i = 0; bus_if.can_move_i = 4'b0000;
        model(1, 4'b0000, 0, 4'b0000);

        // Reset, then start moving left
        step(1, 4'b0000, 0, 4'b0000);
        step(1, 4'b0000, 0, 4'b0000);
        chk("rst_dir", 8'(bus_if.dir_o), 8'h02);
        chk("rst_mov", 8'(bus_if.moving_o), 8'h00);
        step(0, 4'b0000, 1, 4'b0100);
        chk("start_chg", 8'(bus_if.dir_changed_o), 8'h01);
        chk("start_mov", 8'(bus_if.moving_o), 8'h01);
        step(0, 4'b0000, 0, 4'b0000);
        chk("start_chg_once", 8'(bus_if.dir_changed_o), 8'h00);

        // Press up for 3 cycles, two blocked ticks, then an open one
        step(0, 4'b0001, 0, 4'b0000);
        chk("up_press", 8'(bus_if.press_o), 8'h01);
        step(0, 4'b0001, 0, 4'b0000);
        chk("up_press_single", 8'(bus_if.press_o), 8'h00);
        step(0, 4'b0001, 0, 4'b0000);
        step(0, 4'b0000, 1, 4'b0100);
        step(0, 4'b0000, 1, 4'b0100);
        chk("up_armed", 8'(bus_if.pending_valid_o), 8'h01);
        step(0, 4'b0000, 1, 4'b0101);
        chk("up_dir", 8'(bus_if.dir_o), 8'h00);
        chk("up_chg", 8'(bus_if.dir_changed_o), 8'h01);
        chk("up_pv", 8'(bus_if.pending_valid_o), 8'h00);

        // Press down, expire after HOLD ticks
        step(0, 4'b0010, 0, 4'b0000);
        for (int i = 0; i < HOLD; i++) begin
            step(0, 4'b0000, 1, 4'b0001);
            if (i == HOLD - 2) chk("down_armed7", 8'(bus_if.pending_valid_o), 8'h01);
        end
        chk("down_expired", 8'(bus_if.pending_valid_o), 8'h00);
        step(0, 4'b0000, 1, 4'b0011);
        chk("down_nochange", 8'(bus_if.dir_o), 8'h00);

        // Move right, then hit a wall
        step(0, 4'b1000, 1, 4'b1000);
        step(0, 4'b0000, 1, 4'b0000);
        chk("wall_mov", 8'(bus_if.moving_o), 8'h00);
        chk("wall_dir", 8'(bus_if.dir_o), 8'h03);
        chk("wall_chg", 8'(bus_if.dir_changed_o), 8'h00);

        // Up and right rise together on a tick
        step(0, 4'b1001, 1, 4'b1001);
        chk("dual_dir", 8'(bus_if.dir_o), 8'h00);
        chk("dual_press", 8'(bus_if.press_o), 8'h01);
        chk("dual_chg", 8'(bus_if.dir_changed_o), 8'h01);
        step(0, 4'b0000, 0, 4'b0000);

        // Arm left, run timer down to 5, reset with left held
        step(0, 4'b0100, 0, 4'b0000);
        step(0, 4'b0100, 1, 4'b0000);
        step(0, 4'b0100, 1, 4'b0000);
        step(0, 4'b0100, 1, 4'b0000);
        chk("pre_rst_pv", 8'(bus_if.pending_valid_o), 8'h01);
        step(1, 4'b0100, 1, 4'b0100);
        chk("rst2_pv", 8'(bus_if.pending_valid_o), 8'h00);
        chk("rst2_dir", 8'(bus_if.dir_o), 8'h02);
        step(0, 4'b0100, 0, 4'b0000);
        chk("held_press", 8'(bus_if.press_o), 8'h01);
        step(0, 4'b0100, 0, 4'b0000);
        chk("held_press_once", 8'(bus_if.press_o), 8'h00);

        // Random traffic
        rb = 4'b0000;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) rb = 4'($urandom);
            step(($urandom_range(0, 63) == 0), rb, ($urandom_range(0, 2) == 0), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
